// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale pipeline (gray stage and 3x3 window stage).
// Holds the default pixel width and image dimensions, plus tap indices into window_o.
// Tap k = 3*r + c: r=0 is the top (oldest) row, c=0 is the left (oldest) column.
package gray_pkg;

  localparam int GRAY_DATA_WIDTH = 8;
  localparam int IMG_WIDTH_DEF   = 640;
  localparam int IMG_HEIGHT_DEF  = 480;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;
  localparam int NUM_TAPS = 9;

endpackage

// File: rtl/gray_window_3x3_line_buffer.sv
// One image line of pixel storage, addressed by column.
// Latency: dout is a combinational read of the addressed entry; the write lands at the clock edge.
// No backpressure: a write happens on every cycle with en=1 (read-before-write, dout shows old data).
// Ports: clk, en (write enable), addr (column), din (new pixel), dout (previous content at addr).
// Contents are deliberately not reset; the consumer gates on row count instead.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Old data is visible during the write cycle, which is what lets LB1 be fed from LB0's dout.
  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/gray_window_3x3.sv
// 3x3 neighbourhood generator over a raster-order grayscale stream, interior pixels only.
// Latency: one cycle from accepting pixel (row,col) to the window centred on (row-1,col-1).
// No backpressure: every valid_i cycle is accepted; idle cycles hold all state and drop valid_o.
// Ports: clk, rst (sync, active-high), gray_i/valid_i (pixel in),
//        window_o (9 taps, tap k at [k*DATA_WIDTH +: DATA_WIDTH]), valid_o (window pulse), done_o (last window).
module gray_window_3x3
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = GRAY_DATA_WIDTH,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   gray_i,
  input  logic                    valid_i,
  output logic [9*DATA_WIDTH-1:0] window_o,
  output logic                    valid_o,
  output logic                    done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic valid_q, valid_d;
  logic done_q, done_d;

  logic [DATA_WIDTH-1:0] lb0_dout;  // pixel at (row-1, col)
  logic [DATA_WIDTH-1:0] lb1_dout;  // pixel at (row-2, col)

  // LB0 holds the previous line; LB1 is fed LB0's outgoing value, so it lags one line further.
  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) u_lb0 (
    .clk  (clk),
    .en   (valid_i),
    .addr (col_q),
    .din  (gray_i),
    .dout (lb0_dout)
  );

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) u_lb1 (
    .clk  (clk),
    .en   (valid_i),
    .addr (col_q),
    .din  (lb0_dout),
    .dout (lb1_dout)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (valid_i) begin
      // Shift columns left; the new right column is the vertical slice at the current col.
      win_d[TAP_TL] = win_q[TAP_TC];
      win_d[TAP_TC] = win_q[TAP_TR];
      win_d[TAP_TR] = lb1_dout;
      win_d[TAP_ML] = win_q[TAP_C];
      win_d[TAP_C]  = win_q[TAP_MR];
      win_d[TAP_MR] = lb0_dout;
      win_d[TAP_BL] = win_q[TAP_BC];
      win_d[TAP_BC] = win_q[TAP_BR];
      win_d[TAP_BR] = gray_i;

      // By col 2 the two columns left over from the previous line have been shifted out,
      // and row >= 2 guarantees both line buffers hold data from this frame.
      valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign window_o = win_q;
  assign valid_o  = valid_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
module tb_gray_window_3x3;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] gray_i;
  logic          valid_i;
  logic [9*DW-1:0] window_o;
  logic          valid_o;
  logic          done_o;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent send_frame call.
  int          fr_wins;
  int          fr_dones;
  logic [15:0] fr_mask;
  logic [71:0] fr_first;
  logic [71:0] fr_last;

  gray_window_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_i   (gray_i),
    .valid_i  (valid_i),
    .window_o (window_o),
    .valid_o  (valid_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, and settle 1 time unit past it for sampling.
  task automatic cycle(input logic v, input logic [DW-1:0] g);
    valid_i = v;
    gray_i  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    rst = 1'b0;
  endtask

  // Window centred on (r-1,c-1) for frame pixel value base + 4*row + col.
  function automatic logic [71:0] model_win(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[k*DW +: DW] = DW'(base + 4 * (r - 2 + k / 3) + (c - 2 + k % 3));
    end
    return w;
  endfunction

  // Stream one frame; idle cycles inserted at random when gaps=1. Every accept and idle cycle is checked.
  task automatic send_frame(input int base, input bit gaps, input string tag);
    bit exp_v, exp_d;
    fr_wins  = 0;
    fr_dones = 0;
    fr_mask  = '0;
    fr_first = '0;
    fr_last  = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (gaps && ($urandom_range(0, 1) == 0)) begin
          cycle(1'b0, 8'hEE);
          n_cmp++;
          if (valid_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_cycle r%0d c%0d: valid_o=%b done_o=%b, required 0/0", tag, r, c, valid_o, done_o);
          end
        end
        cycle(1'b1, DW'(base + 4 * r + c));
        exp_v = (r >= 2) && (c >= 2);
        exp_d = (r == H - 1) && (c == W - 1);
        n_cmp++;
        if (valid_o !== exp_v || done_o !== exp_d) begin
          n_err++;
          $display("FAIL %s flags r%0d c%0d: valid_o=%b done_o=%b, required %b/%b", tag, r, c, valid_o, done_o, exp_v, exp_d);
        end
        if (valid_o === 1'b1) begin
          fr_mask[4 * r + c] = 1'b1;
          if (fr_wins == 0) fr_first = window_o;
          fr_last = window_o;
          fr_wins++;
        end
        if (done_o === 1'b1) fr_dones++;
        if (exp_v) begin
          n_cmp++;
          if (window_o !== model_win(base, r, c)) begin
            n_err++;
            $display("FAIL %s window r%0d c%0d: got %h, required %h", tag, r, c, window_o, model_win(base, r, c));
          end
        end
      end
    end
  endtask

  task automatic check_counts(input string tag);
    n_cmp++;
    if (fr_wins != 4 || fr_dones != 1) begin
      n_err++;
      $display("FAIL %s counts: windows=%0d dones=%0d, required 4/1", tag, fr_wins, fr_dones);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (window_o !== '0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: window_o=%h valid_o=%b done_o=%b, required 0/0/0", window_o, valid_o, done_o);
    end
    // Idle after reset: nothing may change.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h55);
      n_cmp++;
      if (window_o !== '0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle %0d: window_o=%h valid_o=%b done_o=%b, required 0/0/0", i, window_o, valid_o, done_o);
      end
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    send_frame(0, 1'b0, "full");
    check_counts("full");
    n_cmp++;
    if (fr_first !== 72'h0A_09_08_06_05_04_02_01_00) begin
      n_err++;
      $display("FAIL full first_window: got %h, required %h", fr_first, 72'h0A_09_08_06_05_04_02_01_00);
    end
    n_cmp++;
    if (fr_last !== 72'h0F_0E_0D_0B_0A_09_07_06_05) begin
      n_err++;
      $display("FAIL full last_window: got %h, required %h", fr_last, 72'h0F_0E_0D_0B_0A_09_07_06_05);
    end
    // Pulses are one cycle wide.
    cycle(1'b0, '0);
    n_cmp++;
    if (valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL full pulse_width: valid_o=%b done_o=%b, required 0/0", valid_o, done_o);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_frame(0, 1'b1, "gaps");
    check_counts("gaps");
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(0, 1'b0, "b2b_f1");
    check_counts("b2b_f1");
    send_frame(100, 1'b0, "b2b_f2");
    check_counts("b2b_f2");
    n_cmp++;
    if (fr_first !== 72'h6E_6D_6C_6A_69_68_66_65_64) begin
      n_err++;
      $display("FAIL b2b_f2 first_window: got %h, required %h", fr_first, 72'h6E_6D_6C_6A_69_68_66_65_64);
    end
  endtask

  task automatic test_mid_reset();
    int early;
    do_reset();
    early = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, DW'(50 + i));
      if (valid_o === 1'b1) early++;
    end
    rst = 1'b1;
    cycle(1'b0, '0);
    if (valid_o === 1'b1) early++;
    cycle(1'b0, '0);
    if (valid_o === 1'b1) early++;
    rst = 1'b0;
    n_cmp++;
    if (early != 0 || window_o !== '0) begin
      n_err++;
      $display("FAIL midreset pre: valid pulses=%0d window_o=%h, required 0 and 0", early, window_o);
    end
    send_frame(0, 1'b0, "midreset");
    check_counts("midreset");
    n_cmp++;
    if (fr_first !== 72'h0A_09_08_06_05_04_02_01_00) begin
      n_err++;
      $display("FAIL midreset first_window: got %h, required %h", fr_first, 72'h0A_09_08_06_05_04_02_01_00);
    end
  endtask

  task automatic test_line_wrap();
    do_reset();
    send_frame(20, 1'b0, "wrap");
    // Pulses only at (2,2),(2,3),(3,2),(3,3): bits 10,11,14,15.
    n_cmp++;
    if (fr_mask !== 16'hCC00) begin
      n_err++;
      $display("FAIL wrap pulse_mask: got %h, required %h", fr_mask, 16'hCC00);
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    gray_i  = '0;
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_line_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
